wsched_multi: RTL and testbench

WSCHED_MULTI -- requirements
Module: wsched_multi

---
 rtl/wsched_multi.sv | 114 +++++++++++
 tb/tb_wsched_multi.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wsched_multi.sv
// Multi-lane SHA-256 / SHA-1 message schedule generator.
// Each lane keeps a 16-word sliding window holding W[cnt..cnt+15]. The current
// word is always window slot 0. Each advance shifts the window and appends W[cnt+16].
module wsched_multi #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned SHA1_EN = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [511:0]          msg_in_i,
  input  logic                  mode_i,
  input  logic [LANES-1:0]      feed_i,
  input  logic [LANES-1:0]      next_i,
  output logic [32*LANES-1:0]   wout_o,
  output logic [LANES-1:0]      wvalid_o,
  output logic [LANES-1:0]      wlast_o,
  output logic                  busy_o
);

  typedef enum logic {StIdle, StRun} state_e;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic        use_sha1;
    logic [6:0]  last_cnt;
    logic [31:0] sha1_x;
    logic [31:0] new_w;

    // Recurrence for W[cnt+16] taken from the current window contents.
    always_comb begin
      use_sha1 = (SHA1_EN != 0) && mode_q;
      last_cnt = use_sha1 ? 7'd79 : 7'd63;
      sha1_x   = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
      if (use_sha1) begin
        new_w = {sha1_x[30:0], sha1_x[31]};
      end else begin
        new_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
      end
    end

    // Next-state: feed beats next; next is ignored while idle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      win_d   = win_q;
      if (feed_i[i]) begin
        state_d = StRun;
        cnt_d   = '0;
        mode_d  = mode_i;
        for (int k = 0; k < 16; k++) begin
          win_d[k] = msg_in_i[511-32*k -: 32];
        end
      end else if (next_i[i] && (state_q == StRun)) begin
        if (cnt_q == last_cnt) begin
          // Window is left untouched so wout keeps the final word.
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 7'd1;
          for (int k = 0; k < 15; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[15] = new_w;
        end
      end
    end

    // Lane state register with synchronous reset.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        mode_q  <= 1'b0;
        for (int k = 0; k < 16; k++) begin
          win_q[k] <= '0;
        end
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        mode_q  <= mode_d;
        win_q   <= win_d;
      end
    end

    // Lane outputs.
    always_comb begin
      wout_o[32*i +: 32] = win_q[0];
      wvalid_o[i]        = (state_q == StRun);
      wlast_o[i]         = (state_q == StRun) && (cnt_q == last_cnt);
    end
  end

  // Any lane holding a valid word.
  always_comb begin
    busy_o = |wvalid_o;
  end

endmodule

// File: tb/tb_wsched_multi.sv
// Self-checking bench for wsched_multi with a per-cycle scoreboard driven by a
// software schedule model.
module tb_wsched_multi;

  localparam int L = 4;

  logic             clk;
  logic             rst;
  logic [511:0]     msg;
  logic             mode;
  logic [L-1:0]     feed;
  logic [L-1:0]     nxt;
  logic [32*L-1:0]  wout;
  logic [L-1:0]     wvalid;
  logic [L-1:0]     wlast;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  wsched_multi #(.LANES(L), .SHA1_EN(1)) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .msg_in_i (msg),
    .mode_i   (mode),
    .feed_i   (feed),
    .next_i   (nxt),
    .wout_o   (wout),
    .wvalid_o (wvalid),
    .wlast_o  (wlast),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [31:0] w;
    logic        v;
    logic        l;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [31:0] m_w [L][80];
  int          m_cnt [L];
  bit          m_run [L];
  bit          m_mode [L];
  logic [31:0] m_out [L];

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic int last_of(input int ln);
    return m_mode[ln] ? 79 : 63;
  endfunction

  task automatic load_model(input int ln, input logic [511:0] blk, input bit md);
    logic [31:0] x;
    for (int t = 0; t < 16; t++) m_w[ln][t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      if (md) begin
        x = m_w[ln][t-3] ^ m_w[ln][t-8] ^ m_w[ln][t-14] ^ m_w[ln][t-16];
        m_w[ln][t] = {x[30:0], x[31]};
      end else begin
        x = m_w[ln][t-2];
        m_w[ln][t] = (rr(x, 17) ^ rr(x, 19) ^ (x >> 10)) + m_w[ln][t-7] + m_w[ln][t-16];
        x = m_w[ln][t-15];
        m_w[ln][t] = m_w[ln][t] + (rr(x, 7) ^ rr(x, 18) ^ (x >> 3));
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model and queue expectations.
  task automatic step(input logic [L-1:0] f, input logic [L-1:0] n, input bit r);
    exp_t e;
    bit   any;
    feed = f;
    nxt  = n;
    rst  = r;
    for (int ln = 0; ln < L; ln++) begin
      if (r) begin
        m_run[ln] = 0;
        m_cnt[ln] = 0;
        m_out[ln] = '0;
        m_mode[ln] = 0;
      end else if (f[ln]) begin
        load_model(ln, msg, mode);
        m_mode[ln] = mode;
        m_cnt[ln]  = 0;
        m_run[ln]  = 1;
        m_out[ln]  = m_w[ln][0];
      end else if (n[ln] && m_run[ln]) begin
        if (m_cnt[ln] == last_of(ln)) begin
          m_run[ln] = 0;
        end else begin
          m_cnt[ln]++;
          m_out[ln] = m_w[ln][m_cnt[ln]];
        end
      end
    end
    any = 0;
    for (int ln = 0; ln < L; ln++) begin
      e.lane = ln;
      e.w    = m_out[ln];
      e.v    = m_run[ln];
      e.l    = m_run[ln] && (m_cnt[ln] == last_of(ln));
      exp_q.push_back(e);
      any |= m_run[ln];
    end
    e.lane = L;
    e.w    = {31'b0, any};
    e.v    = 1'b0;
    e.l    = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic repeat_step(input logic [L-1:0] n, input int count);
    for (int k = 0; k < count; k++) step('0, n, 0);
  endtask

  task automatic rand_msg();
    for (int k = 0; k < 16; k++) msg[511-32*k -: 32] = $urandom;
  endtask

  // Scoreboard: pop what was queued for this edge and compare.
  always @(posedge clk) begin : sb
    exp_t e;
    logic [31:0] gw;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.lane == L) begin
        n_cmp++;
        if (busy !== e.w[0]) begin
          n_err++;
          $display("FAIL sb_busy t=%0t got %b expected %b", $time, busy, e.w[0]);
        end
      end else begin
        gw = wout[32*e.lane +: 32];
        n_cmp++;
        if (gw !== e.w) begin
          n_err++;
          $display("FAIL sb_wout lane%0d t=%0t got %h expected %h", e.lane, $time, gw, e.w);
        end
        n_cmp++;
        if (wvalid[e.lane] !== e.v) begin
          n_err++;
          $display("FAIL sb_wvalid lane%0d t=%0t got %b expected %b", e.lane, $time,
                   wvalid[e.lane], e.v);
        end
        n_cmp++;
        if (wlast[e.lane] !== e.l) begin
          n_err++;
          $display("FAIL sb_wlast lane%0d t=%0t got %b expected %b", e.lane, $time,
                   wlast[e.lane], e.l);
        end
      end
    end
  end

  task automatic test_reset();
    step('0, '0, 1);
    n_cmp++;
    if ({wout, wvalid, wlast, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h expected 0", {wout, wvalid, wlast, busy});
    end
    step('0, '0, 0);
  endtask

  task automatic test_sha256_abc();
    msg = '0;
    msg[511:480] = 32'h61626380;
    msg[31:0]    = 32'h00000018;
    mode = 1'b0;
    step(4'b0001, '0, 0);
    n_cmp++;
    if (wout[31:0] !== 32'h61626380) begin
      n_err++;
      $display("FAIL abc256_w0 got %h expected 61626380", wout[31:0]);
    end
    repeat_step(4'b0001, 16);
    n_cmp++;
    if (wout[31:0] !== 32'h61626380) begin
      n_err++;
      $display("FAIL abc256_w16 got %h expected 61626380", wout[31:0]);
    end
    step('0, 4'b0001, 0);
    n_cmp++;
    if (wout[31:0] !== 32'h000F0000) begin
      n_err++;
      $display("FAIL abc256_w17 got %h expected 000f0000", wout[31:0]);
    end
    repeat_step(4'b0001, 46);
    n_cmp++;
    if (wlast[0] !== 1'b1 || dut.g_lane[0].cnt_q !== 7'd63) begin
      n_err++;
      $display("FAIL abc256_last got wlast=%b cnt=%0d expected 1/63", wlast[0],
               dut.g_lane[0].cnt_q);
    end
    repeat_step(4'b0001, 3);
    n_cmp++;
    if (wvalid[0] !== 1'b0 || wout[31:0] !== m_w[0][63]) begin
      n_err++;
      $display("FAIL abc256_idle got v=%b w=%h expected 0/%h", wvalid[0], wout[31:0],
               m_w[0][63]);
    end
  endtask

  task automatic test_sha1_abc();
    msg = '0;
    msg[511:480] = 32'h61626380;
    msg[31:0]    = 32'h00000018;
    mode = 1'b1;
    step(4'b0010, '0, 0);
    mode = 1'b0;
    repeat_step(4'b0010, 16);
    n_cmp++;
    if (wout[63:32] !== 32'hC2C4C700) begin
      n_err++;
      $display("FAIL abc1_w16 got %h expected c2c4c700", wout[63:32]);
    end
    repeat_step(4'b0010, 63);
    n_cmp++;
    if (wlast[1] !== 1'b1) begin
      n_err++;
      $display("FAIL abc1_wlast79 got %b expected 1", wlast[1]);
    end
    step('0, 4'b0010, 0);
    n_cmp++;
    if (wvalid[1] !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abc1_done got v=%b busy=%b expected 0/0", wvalid[1], busy);
    end
  endtask

  task automatic test_feed_next_collision();
    logic [31:0] w0;
    mode = 1'b0;
    for (int ln = 0; ln < L; ln++) begin
      rand_msg();
      step(L'(1) << ln, '0, 0);
    end
    repeat_step('1, 20);
    rand_msg();
    w0 = msg[511:480];
    step(4'b0100, '1, 0);
    n_cmp++;
    if (wout[95:64] !== w0 || wlast[2] !== 1'b0) begin
      n_err++;
      $display("FAIL collide_lane2 got w=%h l=%b expected %h/0", wout[95:64], wlast[2], w0);
    end
    n_cmp++;
    if (wout[31:0] !== m_w[0][21] || wout[127:96] !== m_w[3][21]) begin
      n_err++;
      $display("FAIL collide_others got %h %h expected %h %h", wout[31:0], wout[127:96],
               m_w[0][21], m_w[3][21]);
    end
  endtask

  task automatic test_hold();
    rand_msg();
    mode = 1'b0;
    step(4'b1000, '0, 0);
    repeat_step(4'b1000, 5);
    for (int k = 0; k < 10; k++) begin
      mode = ~mode;
      step('0, '0, 0);
    end
    n_cmp++;
    if (wout[127:96] !== m_w[3][5] || wvalid[3] !== 1'b1) begin
      n_err++;
      $display("FAIL hold_lane3 got w=%h v=%b expected %h/1", wout[127:96], wvalid[3],
               m_w[3][5]);
    end
    repeat_step(4'b1000, 58);
    n_cmp++;
    if (wlast[3] !== 1'b1) begin
      n_err++;
      $display("FAIL hold_mode_ignored got wlast=%b expected 1 at W63", wlast[3]);
    end
  endtask

  task automatic test_reset_mid();
    rand_msg();
    mode = 1'b1;
    step(4'b0001, '0, 0);
    repeat_step(4'b0001, 30);
    step(4'b0001, 4'b0001, 1);
    n_cmp++;
    if ({wout, wvalid, wlast, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_mid got %h expected 0", {wout, wvalid, wlast, busy});
    end
    rand_msg();
    mode = 1'b0;
    step(4'b0001, '0, 0);
    n_cmp++;
    if (wout[31:0] !== msg[511:480] || wvalid[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_refeed got w=%h v=%b expected %h/1", wout[31:0], wvalid[0],
               msg[511:480]);
    end
  endtask

  task automatic test_random();
    logic [L-1:0] f;
    for (int ln = 0; ln < L; ln++) begin
      rand_msg();
      mode = 1'($urandom_range(0, 1));
      step(L'(1) << ln, '0, 0);
    end
    for (int c = 0; c < 500; c++) begin
      f = '0;
      if ($urandom_range(0, 29) == 0) begin
        rand_msg();
        f[$urandom_range(0, L-1)] = 1'b1;
      end
      mode = 1'($urandom_range(0, 1));
      step(f, L'($urandom), 0);
    end
    for (int ln = 0; ln < L; ln++) begin
      n_cmp++;
      if (wvalid[ln] !== m_run[ln]) begin
        n_err++;
        $display("FAIL random_end_valid lane%0d got %b expected %b", ln, wvalid[ln],
                 m_run[ln]);
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    msg  = '0;
    mode = 1'b0;
    feed = '0;
    nxt  = '0;
    test_reset();
    test_sha256_abc();
    test_sha1_abc();
    test_feed_next_collision();
    test_hold();
    test_reset_mid();
    test_random();
    step('0, '0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
